// File: rtl/request_encoder_pkg.sv
// Shared defaults and helpers for the request encoder.
// Also carries the default geometry and output-slot reset value.
`ifndef REQUEST_ENCODER_DEFS
`define REQUEST_ENCODER_DEFS
`define RE_NREQ 4
`define RE_AW 2
`define RE_SLOT_RST 0
`endif

package request_encoder_pkg;

    localparam int RE_NREQ_DEF = `RE_NREQ;
    localparam int RE_AW_DEF   = `RE_AW;
    localparam int RE_SLOT_RST = `RE_SLOT_RST;

    // Address width needed to index n request lines.
    function automatic int enc_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/request_encoder_priority_select.sv
// Lowest-index-wins selection: one-hot select, binary index, any flag.
// Purely combinational.
module priority_select #(
    parameter int NREQ = 4,
    parameter int AW   = 2
) (
    input  logic [NREQ-1:0] i_cand,
    output logic [NREQ-1:0] o_sel,
    output logic [AW-1:0]   o_enc,
    output logic            o_any
);

    always_comb begin
        o_sel = '0;
        o_enc = '0;
        o_any = |i_cand;
        // Scan downwards so the lowest set index is written last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_cand[i]) begin
                o_sel    = '0;
                o_sel[i] = 1'b1;
                o_enc    = AW'(i);
            end
        end
    end

endmodule

// File: rtl/request_encoder.sv
// Edge-captured request lines encoded into a registered address slot.
// One grant per cycle through a valid/ready handshake.
module request_encoder
    import request_encoder_pkg::*;
#(
    parameter int NREQ = RE_NREQ_DEF,
    parameter int AW   = RE_AW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic            ready,
    output logic            valid_o,
    output logic [AW-1:0]   addr_o,
    output logic [NREQ-1:0] onehot_o,
    output logic            overflow_o
);

    logic [NREQ-1:0] r_req_q;
    logic [NREQ-1:0] r_pending;
    logic            r_valid;
    logic [AW-1:0]   r_addr;
    logic [NREQ-1:0] r_onehot;
    logic            r_ovf;

    logic [NREQ-1:0] w_edges;
    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_sel;
    logic [AW-1:0]   w_enc;
    logic            w_any;
    logic            w_load;
    logic [NREQ-1:0] w_clr;
    logic [NREQ-1:0] w_merge;

    assign w_edges = req & ~r_req_q;
    assign w_cand  = r_pending & {NREQ{en}};
    assign w_load  = !r_valid || ready;
    assign w_clr   = w_load ? w_sel : '0;
    // A bit being granted this edge may re-pend without counting as a merge.
    assign w_merge = w_edges & r_pending & ~w_clr;

    priority_select #(
        .NREQ (NREQ),
        .AW   (AW)
    ) u_sel (
        .i_cand (w_cand),
        .o_sel  (w_sel),
        .o_enc  (w_enc),
        .o_any  (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q   <= '0;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_addr    <= AW'(RE_SLOT_RST);
            r_onehot  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_req_q <= req;
            if (w_load) begin
                r_valid   <= w_any;
                r_addr    <= w_enc;
                r_onehot  <= w_sel;
                r_pending <= (r_pending & ~w_sel) | w_edges;
            end else begin
                r_pending <= r_pending | w_edges;
            end
            if (|w_merge) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign valid_o    = r_valid;
    assign addr_o     = r_addr;
    assign onehot_o   = r_onehot;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_request_encoder.sv
// Self-checking bench for request_encoder with a bit-array reference model.
module tb_request_encoder;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [N-1:0] req;
    logic         ready;
    logic         valid_o;
    logic [1:0]   addr_o;
    logic [N-1:0] onehot_o;
    logic         overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_reqq [N];
    bit m_pend [N];
    bit m_valid;
    int m_addr;
    bit m_ovf;
    int m_edges;
    int m_merged;
    int m_grants;

    request_encoder #(.NREQ(N), .AW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req        (req),
        .ready      (ready),
        .valid_o    (valid_o),
        .addr_o     (addr_o),
        .onehot_o   (onehot_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    // Reference: grant first, then apply arriving edges to the pending set.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_reqq[i] = 0;
                m_pend[i] = 0;
            end
            m_valid = 0; m_addr = 0; m_ovf = 0;
            m_edges = 0; m_merged = 0; m_grants = 0;
        end else begin
            bit e [N];
            int s;
            for (int i = 0; i < N; i++) e[i] = req[i] && !m_reqq[i];
            if (!m_valid || ready) begin
                s = -1;
                if (en)
                    for (int i = N - 1; i >= 0; i--)
                        if (m_pend[i]) s = i;
                m_valid = (s >= 0);
                m_addr  = (s >= 0) ? s : 0;
                if (s >= 0) begin
                    m_pend[s] = 0;
                    m_grants++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (e[i]) begin
                    m_edges++;
                    if (m_pend[i]) begin
                        m_merged++;
                        m_ovf = 1;
                    end else begin
                        m_pend[i] = 1;
                    end
                end
                m_reqq[i] = req[i];
            end
        end
    end

    function automatic logic [N-1:0] dec(input logic v, input logic [1:0] a);
        logic [N-1:0] r;
        r = '0;
        if (v) r[a] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; ready = 1'b1; req = 4'b1111;
        repeat (3) tick();
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid got %b want 0", valid_o);
        end
        n_checks++;
        if (addr_o !== 2'd0) begin
            n_fail++; $display("FAIL rst_addr got %0d want 0", addr_o);
        end
        n_checks++;
        if (onehot_o !== 4'b0) begin
            n_fail++; $display("FAIL rst_onehot got %b want 0000", onehot_o);
        end
        n_checks++;
        if (overflow_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_ovf got %b want 0", overflow_o);
        end
    endtask

    task automatic test_held_through_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL held_edge1 valid got %b want 0", valid_o);
        end
        for (int k = 0; k < N; k++) begin
            tick();
            n_checks++;
            if (valid_o !== 1'b1 || addr_o !== 2'(k) || onehot_o !== dec(1'b1, 2'(k))) begin
                n_fail++;
                $display("FAIL held_grant%0d got v=%b a=%0d oh=%b want v=1 a=%0d",
                         k, valid_o, addr_o, onehot_o, k);
            end
        end
        req = 4'b0;
        tick();
        n_checks++;
        if (valid_o !== 1'b0 || onehot_o !== 4'b0 || addr_o !== 2'd0) begin
            n_fail++;
            $display("FAIL held_drain got v=%b a=%0d oh=%b want 0", valid_o, addr_o, onehot_o);
        end
    endtask

    task automatic test_stall();
        ready = 1'b0;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (valid_o !== 1'b1 || addr_o !== 2'd2 || onehot_o !== 4'b0100) begin
                n_fail++;
                $display("FAIL stall_hold%0d got v=%b a=%0d oh=%b want v=1 a=2",
                         k, valid_o, addr_o, onehot_o);
            end
            if (k == 1) req = 4'b0001;
            if (k == 2) req = 4'b0000;
            tick();
        end
        ready = 1'b1;
        tick();
        n_checks++;
        if (valid_o !== 1'b1 || addr_o !== 2'd0 || onehot_o !== 4'b0001) begin
            n_fail++;
            $display("FAIL stall_second got v=%b a=%0d oh=%b want v=1 a=0", valid_o, addr_o, onehot_o);
        end
        tick();
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_empty valid got %b want 0", valid_o);
        end
    endtask

    task automatic test_enable();
        en = 1'b0;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (valid_o !== 1'b0) begin
                n_fail++; $display("FAIL en_off%0d valid got %b want 0", k, valid_o);
            end
        end
        en = 1'b1;
        tick();
        n_checks++;
        if (valid_o !== 1'b1 || addr_o !== 2'd1) begin
            n_fail++; $display("FAIL en_on got v=%b a=%0d want v=1 a=1", valid_o, addr_o);
        end
        tick();
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++; $display("FAIL en_drain valid got %b want 0", valid_o);
        end
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            req = 4'b1000;
            tick();
            req = 4'b0000;
            tick();
            n_checks++;
            if (overflow_o !== (p == 2)) begin
                n_fail++;
                $display("FAIL ovf_pulse%0d got %b want %b", p, overflow_o, p == 2);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (overflow_o !== 1'b1 || valid_o !== 1'b1 || addr_o !== 2'd3) begin
                n_fail++;
                $display("FAIL ovf_sticky%0d got o=%b v=%b a=%0d want o=1 v=1 a=3",
                         k, overflow_o, valid_o, addr_o);
            end
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || onehot_o !== 4'b0 || addr_o !== 2'd0 || overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst got v=%b a=%0d oh=%b o=%b want all 0",
                     valid_o, addr_o, onehot_o, overflow_o);
        end
        ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (overflow_o !== 1'b0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst got v=%b o=%b want 0", valid_o, overflow_o);
        end
    endtask

    task automatic test_random();
        int  grants;
        int  pend;
        bit  pv;
        bit  pr;
        logic [N-1:0] exp_oh;
        grants = 0;
        rst_n = 1'b0;
        req = '0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            req   = N'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            en    = ($urandom_range(0, 7) != 0);
            pv    = valid_o;
            pr    = ready;
            tick();
            exp_oh = dec(m_valid, 2'(m_addr));
            n_checks++;
            if (valid_o !== m_valid || addr_o !== 2'(m_addr) || onehot_o !== exp_oh
                || overflow_o !== m_ovf) begin
                n_fail++;
                $display("FAIL rnd_model c=%0d got v=%b a=%0d oh=%b o=%b want v=%b a=%0d oh=%b o=%b",
                         c, valid_o, addr_o, onehot_o, overflow_o, m_valid, m_addr, exp_oh, m_ovf);
            end
            n_checks++;
            if (dec(valid_o, addr_o) !== onehot_o) begin
                n_fail++;
                $display("FAIL rnd_decoder c=%0d got %b want %b", c, onehot_o, dec(valid_o, addr_o));
            end
            if (valid_o && (!pv || pr)) grants++;
        end
        pend = 0;
        for (int i = 0; i < N; i++) pend += int'(m_pend[i]);
        n_checks++;
        if (grants + pend + m_merged !== m_edges) begin
            n_fail++;
            $display("FAIL rnd_accounting got %0d want %0d", grants + pend + m_merged, m_edges);
        end
        n_checks++;
        if (grants !== m_grants) begin
            n_fail++; $display("FAIL rnd_grants got %0d want %0d", grants, m_grants);
        end
    endtask

    initial begin
        test_reset();
        test_held_through_reset();
        test_stall();
        test_enable();
        test_overflow();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
